// File: rtl/weight_mem_pkg.sv
// rtl/weight_mem_pkg.sv - layer codes, weight-memory geometry and FSM states
package weight_mem_pkg;

  localparam int DEF_INPUT_NODES  = 2;
  localparam int DEF_H1_NODES     = 24;
  localparam int DEF_H2_NODES     = 24;
  localparam int DEF_OUTPUT_NODES = 3;

  localparam int LAYER_IN  = 0;
  localparam int LAYER_H1  = 1;
  localparam int LAYER_H2  = 2;
  localparam int LAYER_OUT = 3;

  // Each output node of a layer owns one weight per input node plus a bias.
  function automatic int layer_size(input int n_out, input int n_in);
    return n_out * (n_in + 1);
  endfunction

  localparam int L1_SIZE = layer_size(DEF_H1_NODES, DEF_INPUT_NODES);
  localparam int L2_SIZE = layer_size(DEF_H2_NODES, DEF_H1_NODES);
  localparam int L3_SIZE = layer_size(DEF_OUTPUT_NODES, DEF_H2_NODES);

  localparam int L1_BASE = 0;
  localparam int L2_BASE = L1_BASE + L1_SIZE;
  localparam int L3_BASE = L2_BASE + L2_SIZE;

  localparam int TOTAL_WEIGHTS   = L3_BASE + L3_SIZE;
  localparam int FLAT_ADDR_WIDTH = $clog2(TOTAL_WEIGHTS);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

endpackage

// File: rtl/weight_ram_sdp.sv
// rtl/weight_ram_sdp.sv - simple dual-port RAM, one write port, registered read-first read port
module weight_ram_sdp
  import weight_mem_pkg::*;
#(
  parameter int DEPTH      = TOTAL_WEIGHTS,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Both accesses in one block: a colliding read samples the pre-write word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_memory_responder.sv
// rtl/weight_memory_responder.sv - answers layer/address weight requests from one flat cleared RAM
module weight_memory_responder
  import weight_mem_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int NUMBER_OF_INPUT_NODE          = DEF_INPUT_NODES,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = DEF_H1_NODES,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = DEF_H2_NODES,
  parameter int NUMBER_OF_OUTPUT_NODE         = DEF_OUTPUT_NODES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_weight_valid_request,
  input  logic [LAYER_WIDTH-1:0]          i_weight_layer_request,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr_request,
  input  logic                            i_write_valid,
  input  logic [LAYER_WIDTH-1:0]          i_write_layer,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_write_addr,
  input  logic [DATA_WIDTH-1:0]           i_write_data,
  output logic                            o_weight_valid,
  output logic [LAYER_WIDTH-1:0]          o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
  output logic [DATA_WIDTH-1:0]           o_weight,
  output logic                            o_ready,
  output logic                            o_addr_error
);

  localparam int H1_SIZE   = layer_size(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_INPUT_NODE);
  localparam int H2_SIZE   = layer_size(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_HIDDEN_NODE_LAYER_1);
  localparam int OUT_SIZE  = layer_size(NUMBER_OF_OUTPUT_NODE, NUMBER_OF_HIDDEN_NODE_LAYER_2);
  localparam int H2_BASE   = H1_SIZE;
  localparam int OUT_BASE  = H1_SIZE + H2_SIZE;
  localparam int N_WEIGHTS = OUT_BASE + OUT_SIZE;
  localparam int RAM_AW    = $clog2(N_WEIGHTS);

  localparam logic [RAM_AW-1:0] LAST_ENTRY = RAM_AW'(N_WEIGHTS - 1);

  typedef struct packed {
    logic              legal;
    logic [RAM_AW-1:0] flat;
  } xlate_t;

  // Layer 0 maps to size 0, so every index into it is rejected.
  function automatic xlate_t translate(input logic [LAYER_WIDTH-1:0] layer,
                                       input logic [WEIGHT_COUNTER_WIDTH-1:0] addr);
    xlate_t r;
    int     a;
    int     size;
    int     base;
    a    = int'(addr);
    size = 0;
    base = 0;
    case (int'(layer))
      LAYER_IN:  size = 0;
      LAYER_H1:  begin size = H1_SIZE;  base = 0;        end
      LAYER_H2:  begin size = H2_SIZE;  base = H2_BASE;  end
      LAYER_OUT: begin size = OUT_SIZE; base = OUT_BASE; end
      default:   size = 0;
    endcase
    r.legal = (a < size);
    r.flat  = RAM_AW'(base + a);
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] clr_cnt_q, clr_cnt_d;

  xlate_t rd_x, wr_x;
  logic   ready;
  logic   rd_accept, wr_accept;
  logic   rd_reject, wr_reject;

  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                            s1_valid_q;
  logic [LAYER_WIDTH-1:0]          s1_layer_q;
  logic [WEIGHT_COUNTER_WIDTH-1:0] s1_addr_q;

  logic                            out_valid_q;
  logic [LAYER_WIDTH-1:0]          out_layer_q;
  logic [WEIGHT_COUNTER_WIDTH-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0]           out_weight_q;
  logic                            addr_error_q;

  assign rd_x  = translate(i_weight_layer_request, i_weight_addr_request);
  assign wr_x  = translate(i_write_layer, i_write_addr);
  assign ready = (state_q == S_READY);

  assign rd_accept = ready & i_weight_valid_request & rd_x.legal;
  assign wr_accept = ready & i_write_valid & wr_x.legal;
  assign rd_reject = i_weight_valid_request & ~rd_accept;
  assign wr_reject = i_write_valid & ~wr_accept;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_we    = 1'b0;
    ram_waddr = wr_x.flat;
    ram_wdata = i_write_data;
    case (state_q)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + RAM_AW'(1);
        if (clr_cnt_q == LAST_ENTRY) begin
          state_d   = S_READY;
          clr_cnt_d = '0;
        end
      end
      S_READY: begin
        ram_we = wr_accept;
      end
      default: begin
        state_d   = S_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  weight_ram_sdp #(
    .DEPTH      (N_WEIGHTS),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (RAM_AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (rd_accept),
    .raddr_i (rd_x.flat),
    .rdata_o (ram_rdata)
  );

  // Stage 1 runs alongside the RAM read; stage 2 lands the word with its echo.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_layer_q   <= '0;
      s1_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_layer_q  <= '0;
      out_addr_q   <= '0;
      out_weight_q <= '0;
      addr_error_q <= 1'b0;
    end else begin
      s1_valid_q   <= rd_accept;
      s1_layer_q   <= i_weight_layer_request;
      s1_addr_q    <= i_weight_addr_request;
      out_valid_q  <= s1_valid_q;
      addr_error_q <= rd_reject | wr_reject;
      if (s1_valid_q) begin
        out_layer_q  <= s1_layer_q;
        out_addr_q   <= s1_addr_q;
        out_weight_q <= ram_rdata;
      end
    end
  end

  assign o_weight_valid = out_valid_q;
  assign o_weight_layer = out_layer_q;
  assign o_weight_addr  = out_addr_q;
  assign o_weight       = out_weight_q;
  assign o_ready        = ready;
  assign o_addr_error   = addr_error_q;

endmodule

// File: tb/tb_weight_memory_responder.sv
// tb/tb_weight_memory_responder.sv - scoreboard bench for weight_memory_responder
module tb_weight_memory_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_weight_valid_request;
  logic [1:0]  i_weight_layer_request;
  logic [10:0] i_weight_addr_request;
  logic        i_write_valid;
  logic [1:0]  i_write_layer;
  logic [10:0] i_write_addr;
  logic [31:0] i_write_data;
  logic        o_weight_valid;
  logic [1:0]  o_weight_layer;
  logic [10:0] o_weight_addr;
  logic [31:0] o_weight;
  logic        o_ready;
  logic        o_addr_error;

  always #5 clk = ~clk;

  weight_memory_responder dut (
    .clk                    (clk),
    .rst                    (rst),
    .i_weight_valid_request (i_weight_valid_request),
    .i_weight_layer_request (i_weight_layer_request),
    .i_weight_addr_request  (i_weight_addr_request),
    .i_write_valid          (i_write_valid),
    .i_write_layer          (i_write_layer),
    .i_write_addr           (i_write_addr),
    .i_write_data           (i_write_data),
    .o_weight_valid         (o_weight_valid),
    .o_weight_layer         (o_weight_layer),
    .o_weight_addr          (o_weight_addr),
    .o_weight               (o_weight),
    .o_ready                (o_ready),
    .o_addr_error           (o_addr_error)
  );

  typedef struct {
    int          layer;
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model [0:746];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = -1;
  int last_err_cyc = -1;
  int run = 0;
  int max_run = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_addr_error === 1'b1) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (o_weight_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      run++;
      if (run > max_run) max_run = run;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_response: got layer=%0d addr=%0d data=%h, required no response",
                 o_weight_layer, o_weight_addr, o_weight);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_weight_layer !== 2'(mon_e.layer) || o_weight_addr !== 11'(mon_e.addr) ||
            o_weight !== mon_e.data) begin
          errors++;
          $display("FAIL response: got layer=%0d addr=%0d data=%h, required layer=%0d addr=%0d data=%h",
                   o_weight_layer, o_weight_addr, o_weight, mon_e.layer, mon_e.addr, mon_e.data);
        end
      end
    end else begin
      run = 0;
    end
  end

  function automatic bit legal(input int l, input int a);
    case (l)
      1: return a < 72;
      2: return a < 600;
      3: return a < 75;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int flat(input int l, input int a);
    if (l == 1) return a;
    if (l == 2) return 72 + a;
    return 672 + a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_weight_valid_request = 1'b0;
    i_weight_layer_request = '0;
    i_weight_addr_request  = '0;
    i_write_valid          = 1'b0;
    i_write_layer          = '0;
    i_write_addr           = '0;
    i_write_data           = '0;
  endtask

  // One cycle of stimulus against a ready DUT; the read is scored before the write lands.
  task automatic cyc_op(input bit rv, input int rl, input int ra,
                        input bit wv, input int wl, input int wa, input logic [31:0] wd);
    exp_t e;
    i_weight_valid_request = rv;
    i_weight_layer_request = 2'(rl);
    i_weight_addr_request  = 11'(ra);
    i_write_valid          = wv;
    i_write_layer          = 2'(wl);
    i_write_addr           = 11'(wa);
    i_write_data           = wd;
    if (rv && legal(rl, ra)) begin
      e.layer = rl;
      e.addr  = ra;
      e.data  = model[flat(rl, ra)];
      exp_q.push_back(e);
    end
    if (wv && legal(wl, wa)) model[flat(wl, wa)] = wd;
    step();
    idle();
  endtask

  task automatic drain(input string name);
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_responses: got %0d outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    checks++;
    if (n != 747) begin
      errors++;
      $display("FAIL %s_ready_latency: got %0d cycles, required 747", name, n);
    end
  endtask

  task automatic test_reset();
    int e0, v0;
    rst = 1'b1;
    idle();
    repeat (3) step();
    checks++;
    if ({o_weight_valid, o_weight_layer, o_weight_addr, o_weight, o_ready, o_addr_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b layer=%0d addr=%0d data=%h ready=%b err=%b, required all 0",
               o_weight_valid, o_weight_layer, o_weight_addr, o_weight, o_ready, o_addr_error);
    end
    foreach (model[i]) model[i] = '0;
    e0 = err_cnt;
    v0 = valid_cnt;
    rst = 1'b0;
    i_weight_valid_request = 1'b1;
    i_weight_layer_request = 2'd1;
    i_weight_addr_request  = 11'd0;
    step();
    idle();
    i_write_valid = 1'b1;
    i_write_layer = 2'd1;
    i_write_addr  = 11'd3;
    i_write_data  = 32'hDEADBEEF;
    step();
    idle();
    begin : count_rest
      int n;
      n = 2;
      while (o_ready !== 1'b1 && n < 2000) begin
        step();
        n++;
      end
      checks++;
      if (n != 747) begin
        errors++;
        $display("FAIL clear_ready_latency: got %0d cycles, required 747", n);
      end
    end
    checks++;
    if (err_cnt - e0 != 2) begin
      errors++;
      $display("FAIL clear_access_errors: got %0d pulses, required 2", err_cnt - e0);
    end
    checks++;
    if (valid_cnt != v0) begin
      errors++;
      $display("FAIL clear_no_response: got %0d responses, required 0", valid_cnt - v0);
    end
    cyc_op(1, 1, 0,   0, 0, 0, 0);
    cyc_op(1, 2, 599, 0, 0, 0, 0);
    cyc_op(1, 3, 74,  0, 0, 0, 0);
    cyc_op(1, 1, 3,   0, 0, 0, 0);
    drain("reset");
  endtask

  task automatic test_write_read();
    int cap;
    cyc_op(0, 0, 0, 1, 2, 5, 32'h3F800000);
    cyc_op(1, 2, 5, 0, 0, 0, 0);
    cap = cyc;
    drain("write_read");
    checks++;
    if (last_valid_cyc != cap + 1) begin
      errors++;
      $display("FAIL read_latency: got response at cycle %0d, required %0d", last_valid_cyc, cap + 1);
    end
    cyc_op(1, 1, 5, 0, 0, 0, 0);
    drain("write_read_other");
  endtask

  task automatic test_stream();
    int v0;
    for (int i = 0; i < 72; i++) cyc_op(0, 0, 0, 1, 1, i, 32'(i));
    v0 = valid_cnt;
    max_run = 0;
    for (int i = 0; i < 72; i++) cyc_op(1, 1, i, 0, 0, 0, 0);
    drain("stream");
    checks++;
    if (valid_cnt - v0 != 72 || max_run != 72) begin
      errors++;
      $display("FAIL stream_burst: got %0d responses run %0d, required 72 run 72", valid_cnt - v0, max_run);
    end
  endtask

  task automatic test_illegal();
    int e0, v0, cap;
    e0 = err_cnt;
    v0 = valid_cnt;
    cyc_op(1, 0, 0, 1, 2, 600, 32'h12345678);
    cap = cyc;
    step();
    checks++;
    if (err_cnt - e0 != 1 || last_err_cyc != cap) begin
      errors++;
      $display("FAIL dual_illegal_pulse: got %0d pulses at cycle %0d, required 1 at %0d",
               err_cnt - e0, last_err_cyc, cap);
    end
    cyc_op(1, 1, 72, 0, 0, 0, 0);
    cyc_op(1, 3, 75, 0, 0, 0, 0);
    cyc_op(0, 0, 0, 1, 1, 72, 32'h0BADBAD0);
    cyc_op(1, 2, 0, 0, 0, 0, 0);
    cyc_op(1, 1, 71, 0, 0, 0, 0);
    drain("illegal");
    checks++;
    if (err_cnt - e0 != 4) begin
      errors++;
      $display("FAIL illegal_error_count: got %0d pulses, required 4", err_cnt - e0);
    end
    checks++;
    if (valid_cnt - v0 != 2) begin
      errors++;
      $display("FAIL illegal_response_count: got %0d responses, required 2", valid_cnt - v0);
    end
  endtask

  task automatic test_same_cycle();
    cyc_op(0, 0, 0, 1, 3, 10, 32'h3F800000);
    cyc_op(1, 3, 10, 1, 3, 10, 32'h40000000);
    cyc_op(1, 3, 10, 0, 0, 0, 0);
    drain("same_cycle");
  endtask

  task automatic test_reset_midstream();
    int v0;
    v0 = valid_cnt;
    i_weight_valid_request = 1'b1;
    i_weight_layer_request = 2'd2;
    i_weight_addr_request  = 11'd5;
    step();
    i_weight_layer_request = 2'd1;
    i_weight_addr_request  = 11'd0;
    rst = 1'b1;
    step();
    idle();
    checks++;
    if (o_ready !== 1'b0 || o_weight_valid !== 1'b0 || o_weight !== 32'h0) begin
      errors++;
      $display("FAIL midstream_reset_outputs: got ready=%b valid=%b data=%h, required 0 0 00000000",
               o_ready, o_weight_valid, o_weight);
    end
    repeat (2) step();
    rst = 1'b0;
    foreach (model[i]) model[i] = '0;
    wait_ready("midstream");
    checks++;
    if (valid_cnt != v0) begin
      errors++;
      $display("FAIL midstream_discard: got %0d responses, required 0", valid_cnt - v0);
    end
    cyc_op(1, 2, 5, 0, 0, 0, 0);
    cyc_op(1, 3, 10, 0, 0, 0, 0);
    drain("midstream");
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_stream();
    test_illegal();
    test_same_cycle();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
